// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA channel arbiter slice:
//   - default channel count / index width / word-count width
//   - bus-grant sequencer state encoding
//   - one-hot to index conversion helper (sized for the largest channel count)
// -----------------------------------------------------------------------------
package dma_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CH_W   = 2;
  localparam int DEF_CNT_W  = 16;

  // Upper bound of the supported channel range; the helper works on this width
  // and callers cast in/out of it.
  localparam int MAX_CH     = 8;
  localparam int MAX_CH_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } dma_state_t;

  // OR-reduction mapping: exact for a one-hot input, 0 for an all-zero input.
  function automatic logic [MAX_CH_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
    logic [MAX_CH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) begin
        idx = idx | MAX_CH_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// -----------------------------------------------------------------------------
// dma_prio_encoder
// Combinational priority encoder over the effective request vector.
// Fixed mode: lowest index wins. Rotating mode: search starts at i_ptr and
// wraps around, so i_ptr is highest priority and i_ptr-1 lowest.
// Ports:
//   i_req     effective requests, one bit per channel
//   i_rot_pri 0 = fixed priority, 1 = rotating from i_ptr
//   i_ptr     current highest-priority channel for rotating mode
//   o_winner  index of the winning channel (meaningful when o_valid=1)
//   o_valid   at least one request present
// -----------------------------------------------------------------------------
module dma_prio_encoder
  import dma_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_rot_pri,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [CH_W-1:0]   o_winner,
  output logic              o_valid
);

  logic [CH_W-1:0]   w_base;
  logic [NUM_CH-1:0] w_rot;
  logic [NUM_CH-1:0] w_oh;
  logic [CH_W-1:0]   w_idx;

  assign w_base = i_rot_pri ? i_ptr : '0;

  // Rotate right by w_base so the highest-priority channel lands at bit 0;
  // duplicating the vector makes the wrap-around free.
  assign w_rot = NUM_CH'({i_req, i_req} >> w_base);

  // Isolate lowest set bit.
  assign w_oh  = w_rot & (~w_rot + NUM_CH'(1));
  assign w_idx = CH_W'(onehot_to_idx(MAX_CH'(w_oh)));

  // NUM_CH is a power of two, so the CH_W-bit add wraps modulo NUM_CH.
  assign o_winner = w_base + w_idx;
  assign o_valid  = |i_req;

endmodule

// File: rtl/dma_channel_arbiter.sv
// -----------------------------------------------------------------------------
// dma_channel_arbiter
// Request arbiter and bus-grant sequencer for the DMA controller. Arbitrates
// DREQ lines, runs the HRQ/HLDA handshake, issues one single-mode transfer per
// grant and maintains per-channel word counts and terminal-count flags.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-low reset
//   en             controller enable (0 blocks new arbitration)
//   rot_pri        0 = fixed priority, 1 = rotating priority
//   mask, dreq     per-channel software mask / level requests
//   hlda, ready    CPU hold acknowledge / memory-IO ready
//   cnt_wr/ch/data count register write port
//   hrq, aen, dack hold request, address enable, one-hot acknowledge
//   ch_sel         granted channel index (valid while aen=1)
//   xfer_done, tc  completion pulse, terminal-count pulse
//   tc_status      sticky terminal-count flags
// -----------------------------------------------------------------------------
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rot_pri,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] dreq,
  input  logic              hlda,
  input  logic              ready,
  input  logic              cnt_wr,
  input  logic [CH_W-1:0]   cnt_ch,
  input  logic [CNT_W-1:0]  cnt_data,
  output logic              hrq,
  output logic              aen,
  output logic [NUM_CH-1:0] dack,
  output logic [CH_W-1:0]   ch_sel,
  output logic              xfer_done,
  output logic              tc,
  output logic [NUM_CH-1:0] tc_status
);

  dma_state_t        r_state;
  logic              r_hrq;
  logic              r_aen;
  logic [NUM_CH-1:0] r_dack;
  logic [CH_W-1:0]   r_ch_sel;
  logic              r_xfer_done;
  logic              r_tc;
  logic [CH_W-1:0]   r_ptr;
  logic [NUM_CH-1:0] r_tc_status;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];

  dma_state_t        w_state_next;
  logic              w_hrq_next;
  logic              w_aen_next;
  logic [NUM_CH-1:0] w_dack_next;
  logic [CH_W-1:0]   w_ch_sel_next;
  logic              w_xfer_done_next;
  logic              w_tc_next;
  logic [CH_W-1:0]   w_ptr_next;
  logic [NUM_CH-1:0] w_tc_status_next;
  logic [CNT_W-1:0]  w_cnt_next [NUM_CH];

  logic [NUM_CH-1:0] w_req_eff;
  logic [CH_W-1:0]   w_winner;
  logic              w_valid;
  logic              w_complete;
  logic [NUM_CH-1:0] w_wr_hit;
  logic [NUM_CH-1:0] w_dec_hit;
  logic [NUM_CH-1:0] w_cnt_zero;

  // Channels that reached terminal count stay out of arbitration until
  // their count is rewritten.
  assign w_req_eff = dreq & ~mask & ~r_tc_status;

  dma_prio_encoder #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_prio (
    .i_req     (w_req_eff),
    .i_rot_pri (rot_pri),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_valid   (w_valid)
  );

  // A transfer completes only while the bus is still held; hlda=0 takes
  // precedence as an abort.
  assign w_complete = (r_state == ST_XFER) && hlda && ready;

  // Per-channel count / terminal-count update. A register write beats a
  // coincident decrement on the same channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_wr_hit[gi]   = cnt_wr && (cnt_ch == CH_W'(gi));
      assign w_dec_hit[gi]  = w_complete && (r_ch_sel == CH_W'(gi));
      assign w_cnt_zero[gi] = (r_cnt[gi] == '0);

      assign w_cnt_next[gi] = w_wr_hit[gi]  ? cnt_data :
                              w_dec_hit[gi] ? r_cnt[gi] - CNT_W'(1) :
                                              r_cnt[gi];

      assign w_tc_status_next[gi] = w_wr_hit[gi] ? 1'b0 :
                                    (w_dec_hit[gi] && w_cnt_zero[gi]) ? 1'b1 :
                                    r_tc_status[gi];
    end
  endgenerate

  always_comb begin
    w_state_next     = r_state;
    w_hrq_next       = r_hrq;
    w_aen_next       = r_aen;
    w_dack_next      = r_dack;
    w_ch_sel_next    = r_ch_sel;
    w_xfer_done_next = 1'b0;
    w_tc_next        = 1'b0;
    w_ptr_next       = r_ptr;

    case (r_state)
      ST_IDLE: begin
        if (en && (|w_req_eff)) begin
          w_state_next = ST_REQ;
          w_hrq_next   = 1'b1;
        end
      end

      ST_REQ: begin
        if (hlda) begin
          if (en && w_valid) begin
            w_state_next  = ST_XFER;
            w_aen_next    = 1'b1;
            w_dack_next   = NUM_CH'(1) << w_winner;
            w_ch_sel_next = w_winner;
          end else begin
            // Request withdrawn or controller disabled: hand the bus back.
            w_state_next = ST_REL;
            w_hrq_next   = 1'b0;
          end
        end
      end

      ST_XFER: begin
        if (!hlda) begin
          w_state_next = ST_REL;
          w_hrq_next   = 1'b0;
          w_aen_next   = 1'b0;
          w_dack_next  = '0;
        end else if (ready) begin
          w_state_next     = ST_REL;
          w_hrq_next       = 1'b0;
          w_aen_next       = 1'b0;
          w_dack_next      = '0;
          w_xfer_done_next = 1'b1;
          w_tc_next        = w_dec_hit[r_ch_sel] && w_cnt_zero[r_ch_sel] &&
                             !w_wr_hit[r_ch_sel];
          // Pointer advances only for completed transfers in rotating mode,
          // so fixed-mode traffic leaves the rotation order untouched.
          if (rot_pri) begin
            w_ptr_next = r_ch_sel + CH_W'(1);
          end
        end
      end

      ST_REL: begin
        if (!hlda) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_hrq       <= 1'b0;
      r_aen       <= 1'b0;
      r_dack      <= '0;
      r_ch_sel    <= '0;
      r_xfer_done <= 1'b0;
      r_tc        <= 1'b0;
      r_ptr       <= '0;
      r_tc_status <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state     <= w_state_next;
      r_hrq       <= w_hrq_next;
      r_aen       <= w_aen_next;
      r_dack      <= w_dack_next;
      r_ch_sel    <= w_ch_sel_next;
      r_xfer_done <= w_xfer_done_next;
      r_tc        <= w_tc_next;
      r_ptr       <= w_ptr_next;
      r_tc_status <= w_tc_status_next;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign hrq       = r_hrq;
  assign aen       = r_aen;
  assign dack      = r_dack;
  assign ch_sel    = r_ch_sel;
  assign xfer_done = r_xfer_done;
  assign tc        = r_tc;
  assign tc_status = r_tc_status;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_channel_arbiter
// Cycle table for handshake / abort / reset / collision cases, followed by
// hand-written grant sequences for priority modes and wait states.
// -----------------------------------------------------------------------------
module tb_dma_channel_arbiter;

  logic        clk;
  logic        reset;
  logic        en;
  logic        rot_pri;
  logic [3:0]  mask;
  logic [3:0]  dreq;
  logic        hlda;
  logic        ready;
  logic        cnt_wr;
  logic [1:0]  cnt_ch;
  logic [15:0] cnt_data;
  logic        hrq;
  logic        aen;
  logic [3:0]  dack;
  logic [1:0]  ch_sel;
  logic        xfer_done;
  logic        tc;
  logic [3:0]  tc_status;

  int checks;
  int failures;

  dma_channel_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .rot_pri   (rot_pri),
    .mask      (mask),
    .dreq      (dreq),
    .hlda      (hlda),
    .ready     (ready),
    .cnt_wr    (cnt_wr),
    .cnt_ch    (cnt_ch),
    .cnt_data  (cnt_data),
    .hrq       (hrq),
    .aen       (aen),
    .dack      (dack),
    .ch_sel    (ch_sel),
    .xfer_done (xfer_done),
    .tc        (tc),
    .tc_status (tc_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       rot;
    logic [3:0] mask;
    logic [3:0] dreq;
    logic       hlda;
    logic       ready;
    logic       wr;
    logic [1:0] wch;
    logic [15:0] wdata;
    logic       hrq;
    logic       aen;
    logic [3:0] dack;
    logic [1:0] sel;
    logic       done;
    logic       tc;
    logic [3:0] tcs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic rst_n, input logic e, input logic rot, input logic [3:0] m,
    input logic [3:0] dr, input logic hl, input logic rdy, input logic wr,
    input logic [1:0] wch, input logic [15:0] wd,
    input logic x_hrq, input logic x_aen, input logic [3:0] x_dack,
    input logic [1:0] x_sel, input logic x_done, input logic x_tc,
    input logic [3:0] x_tcs);
    vec_t t;
    t.rst_n = rst_n; t.en = e; t.rot = rot; t.mask = m; t.dreq = dr;
    t.hlda = hl; t.ready = rdy; t.wr = wr; t.wch = wch; t.wdata = wd;
    t.hrq = x_hrq; t.aen = x_aen; t.dack = x_dack; t.sel = x_sel;
    t.done = x_done; t.tc = x_tc; t.tcs = x_tcs;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; en = 1'b0; rot_pri = 1'b0; mask = '0; dreq = '0;
    hlda = 1'b0; ready = 1'b0; cnt_wr = 1'b0; cnt_ch = '0; cnt_data = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic wr_cnt(input logic [1:0] ch, input logic [15:0] data);
    cnt_wr = 1'b1; cnt_ch = ch; cnt_data = data;
    step();
    cnt_wr = 1'b0;
  endtask

  // One complete grant: wait for hrq, acknowledge, hold ready low for
  // 'waits' cycles, complete, then release the bus.
  task automatic grant(input string tag, input int exp_ch, input logic exp_tc, input int waits);
    int n;
    logic [3:0] exp_dack;
    exp_dack = 4'b0001 << exp_ch;
    n = 0;
    hlda = 1'b0; ready = 1'b0;
    while (!hrq && n < 20) begin
      step();
      n++;
    end
    chk({tag, " hrq"}, 32'(hrq), 32'(1));
    hlda = 1'b1;
    step();
    chk({tag, " aen"}, 32'(aen), 32'(1));
    chk({tag, " ch_sel"}, 32'(ch_sel), 32'(exp_ch));
    chk({tag, " dack"}, 32'(dack), 32'(exp_dack));
    for (int w = 0; w < waits; w++) begin
      step();
      chk($sformatf("%s wait%0d dack", tag, w), 32'(dack), 32'(exp_dack));
      chk($sformatf("%s wait%0d done", tag, w), 32'(xfer_done), 32'(0));
    end
    ready = 1'b1;
    step();
    chk({tag, " xfer_done"}, 32'(xfer_done), 32'(1));
    chk({tag, " tc"}, 32'(tc), 32'(exp_tc));
    chk({tag, " dack_off"}, 32'(dack), 32'(0));
    ready = 1'b0; hlda = 1'b0;
    step();
    $display("grant %s ch=%0d tc=%0b", tag, ch_sel, tc);
  endtask

  initial begin
    vec_t t;
    checks = 0;
    failures = 0;
    reset = 1'b0; en = 1'b0; rot_pri = 1'b0; mask = '0; dreq = '0;
    hlda = 1'b0; ready = 1'b0; cnt_wr = 1'b0; cnt_ch = '0; cnt_data = '0;

    //              rst en rot mask dreq hl rdy wr wch wd   hrq aen dack sel dn tc tcs
    // basic grant on ch2 with count 0
    vecs.push_back(v(0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(v(1, 0, 0, 4'h0, 4'h0, 0, 0, 1, 2, 0,   0, 0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 0, 0, 0, 0, 0,   1, 0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 0, 0, 0, 0, 0,   1, 0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 0, 0, 0, 0, 0,   1, 0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 0, 0, 0, 0, 0,   1, 0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 1, 0, 0, 0, 0,   1, 1, 4'h4, 2, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 1, 1, 0, 0, 0,   0, 0, 4'h0, 2, 1, 1, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 1, 0, 0, 0, 0,   0, 0, 4'h0, 2, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 0, 0, 0, 0, 0,   0, 0, 4'h0, 2, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 0, 0, 0, 0, 0,   0, 0, 4'h0, 2, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h4, 0, 0, 0, 0, 0,   0, 0, 4'h0, 2, 0, 0, 4'h4));
    // withdrawn request on ch0
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h1, 0, 0, 0, 0, 0,   1, 0, 4'h0, 2, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   1, 0, 4'h0, 2, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0,   0, 0, 4'h0, 2, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0,   0, 0, 4'h0, 2, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 4'h0, 2, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 4'h0, 2, 0, 0, 4'h4));
    // abort on ch1 (count 0), then completion proves count untouched
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 0, 0, 1, 1, 0,   1, 0, 4'h0, 2, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 1, 0, 0, 0, 0,   1, 1, 4'h2, 1, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 0, 1, 0, 0, 0,   0, 0, 4'h0, 1, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 0, 0, 0, 0, 0,   0, 0, 4'h0, 1, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 0, 0, 0, 0, 0,   1, 0, 4'h0, 1, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 1, 0, 0, 0, 0,   1, 1, 4'h2, 1, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 1, 1, 0, 0, 0,   0, 0, 4'h0, 1, 1, 1, 4'h6));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 1, 0, 1, 1, 0,   0, 0, 4'h0, 1, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 0, 0, 0, 0, 0,   0, 0, 4'h0, 1, 0, 0, 4'h4));
    // reset mid-transfer
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 0, 0, 0, 0, 0,   1, 0, 4'h0, 1, 0, 0, 4'h4));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 1, 0, 0, 0, 0,   1, 1, 4'h2, 1, 0, 0, 4'h4));
    vecs.push_back(v(0, 1, 0, 4'h0, 4'h2, 1, 0, 0, 0, 0,   0, 0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 4'h0, 0, 0, 0, 4'h0));
    // write collision: ch1 completes at count 0 while 7 is written
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 0, 0, 1, 1, 0,   1, 0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 1, 0, 0, 0, 0,   1, 1, 4'h2, 1, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 1, 1, 1, 1, 7,   0, 0, 4'h0, 1, 1, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 0, 0, 0, 0, 0,   0, 0, 4'h0, 1, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 0, 0, 0, 0, 0,   1, 0, 4'h0, 1, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 1, 0, 0, 0, 0,   1, 1, 4'h2, 1, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h2, 1, 1, 0, 0, 0,   0, 0, 4'h0, 1, 1, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 4'h0, 1, 0, 0, 4'h0));
    // mask and enable gate new requests
    vecs.push_back(v(1, 1, 0, 4'h2, 4'h2, 0, 0, 0, 0, 0,   0, 0, 4'h0, 1, 0, 0, 4'h0));
    vecs.push_back(v(1, 0, 0, 4'h0, 4'h2, 0, 0, 0, 0, 0,   0, 0, 4'h0, 1, 0, 0, 4'h0));
    vecs.push_back(v(1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 4'h0, 1, 0, 0, 4'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      reset = t.rst_n; en = t.en; rot_pri = t.rot; mask = t.mask; dreq = t.dreq;
      hlda = t.hlda; ready = t.ready; cnt_wr = t.wr; cnt_ch = t.wch; cnt_data = t.wdata;
      step();
      chk($sformatf("row%0d hrq", i), 32'(hrq), 32'(t.hrq));
      chk($sformatf("row%0d aen", i), 32'(aen), 32'(t.aen));
      chk($sformatf("row%0d dack", i), 32'(dack), 32'(t.dack));
      chk($sformatf("row%0d ch_sel", i), 32'(ch_sel), 32'(t.sel));
      chk($sformatf("row%0d xfer_done", i), 32'(xfer_done), 32'(t.done));
      chk($sformatf("row%0d tc", i), 32'(tc), 32'(t.tc));
      chk($sformatf("row%0d tc_status", i), 32'(tc_status), 32'(t.tcs));
      $display("row %0d hrq=%0b aen=%0b dack=%b sel=%0d done=%0b tc=%0b tcs=%b",
               i, hrq, aen, dack, ch_sel, xfer_done, tc, tc_status);
    end

    // Fixed then rotating priority, all channels count 5.
    do_reset();
    for (int c = 0; c < 4; c++) wr_cnt(2'(c), 16'd5);
    en = 1'b1; dreq = 4'hF; rot_pri = 1'b0;
    for (int g = 0; g < 4; g++) grant($sformatf("fixed%0d", g), 0, 1'b0, 0);
    rot_pri = 1'b1;
    grant("rot0", 0, 1'b0, 0);
    grant("rot1", 1, 1'b0, 0);
    grant("rot2", 2, 1'b0, 0);
    grant("rot3", 3, 1'b0, 0);
    grant("rot4", 0, 1'b1, 0);
    chk("rot tc_status", 32'(tc_status), 32'(4'h1));
    grant("rot5", 1, 1'b0, 0);
    dreq = 4'h0;
    step();

    // Wait states on ch3 with count 5: 6 transfers total, tc on the last.
    do_reset();
    wr_cnt(2'd3, 16'd5);
    en = 1'b1; dreq = 4'h8; rot_pri = 1'b0;
    grant("wait", 3, 1'b0, 4);
    for (int g = 0; g < 4; g++) grant($sformatf("cnt%0d", g), 3, 1'b0, 0);
    grant("cnt_last", 3, 1'b1, 0);
    chk("wait tc_status", 32'(tc_status), 32'(4'h8));
    dreq = 4'h0;
    step();
    chk("wait idle hrq", 32'(hrq), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
